// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered load, hex/BCD decode, LZ blanking.
// Latency: outputs registered one cycle after the state they reflect; load becomes visible at next frame commit.
// Backpressure: none; load is always accepted, last load before a commit wins.
module seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   load,
    input  logic [4*DIGITS-1:0]                    value,
    input  logic [DIGITS-1:0]                      dp_in,
    input  logic                                   hex_mode,
    input  logic                                   lz_blank,
    output logic [6:0]                             seg_n,
    output logic                                   dp_n,
    output logic [DIGITS-1:0]                      an_n,
    output logic [((DIGITS>1)?$clog2(DIGITS):1)-1:0] digit_idx,
    output logic                                   frame_start,
    output logic                                   bcd_err
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V   = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         slot_cnt, slot_nxt;
    logic [IW-1:0]         idx_nxt;
    logic [4*DIGITS-1:0]   act_val, act_nxt, pend_val;
    logic [DIGITS-1:0]     act_dp, adp_nxt, pend_dp;
    logic                  pend, commit;
    logic [3:0]            nib;
    logic                  dp_bit, upper_nz, any_bad;
    logic [6:0]            seg_nxt;
    logic [DIGITS-1:0]     an_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h18; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_nxt = slot_cnt;
        idx_nxt  = digit_idx;
        commit   = 1'b0;
        if (en) begin
            if (slot_cnt == SLOT_LAST) begin
                slot_nxt = '0;
                if (digit_idx == IDX_LAST) begin
                    idx_nxt = '0;
                    commit  = 1'b1;
                end else begin
                    idx_nxt = digit_idx + 1'b1;
                end
            end else begin
                slot_nxt = slot_cnt + 1'b1;
            end
        end

        // A load coinciding with the commit bypasses the pending buffer.
        act_nxt = act_val;
        adp_nxt = act_dp;
        if (commit && load) begin
            act_nxt = value;
            adp_nxt = dp_in;
        end else if (commit && pend) begin
            act_nxt = pend_val;
            adp_nxt = pend_dp;
        end

        nib      = 4'd0;
        dp_bit   = 1'b0;
        upper_nz = 1'b0;
        any_bad  = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_nxt) begin
                nib    = act_nxt[4*j +: 4];
                dp_bit = adp_nxt[j];
            end
            if (j >= int'(idx_nxt) && act_nxt[4*j +: 4] != 4'd0)
                upper_nz = 1'b1;
            if (act_nxt[4*j +: 4] > 4'd9)
                any_bad = 1'b1;
            an_nxt[j] = !(en && slot_nxt >= BLANK_V && IW'(j) == idx_nxt);
        end

        seg_nxt = 7'h7F;
        if (en) begin
            if (lz_blank && idx_nxt != '0 && !upper_nz)
                seg_nxt = 7'h7F;
            else if (!hex_mode && nib > 4'd9)
                seg_nxt = 7'h3F;
            else
                seg_nxt = hex7(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            act_val     <= '0;
            act_dp      <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend        <= 1'b0;
            an_n        <= '1;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
            bcd_err     <= 1'b0;
        end else begin
            slot_cnt    <= slot_nxt;
            digit_idx   <= idx_nxt;
            act_val     <= act_nxt;
            act_dp      <= adp_nxt;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            if (commit)
                pend <= 1'b0;
            else if (load)
                pend <= 1'b1;
            an_n        <= an_nxt;
            seg_n       <= seg_nxt;
            dp_n        <= !(en && dp_bit);
            frame_start <= commit;
            bcd_err     <= !hex_mode && any_bad;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a frame-position reference model.
module tb_seg_scan_driver;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FR = D * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, load = 1'b0, hex_mode = 1'b1, lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg_n;
    logic        dp_n, frame_start, bcd_err;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
        .hex_mode(hex_mode), .lz_blank(lz_blank), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .digit_idx(digit_idx), .frame_start(frame_start), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    // Reference state: linear position within a frame and the two display buffers.
    int          pos;
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pend, m_fs, m_rst;
    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)", tag, got, exp, pos, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit ld, input logic [15:0] v,
                        input logic [3:0] d, input bit hx, input bit lz);
        int dig, slot;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        bit bad;
        @(negedge clk);
        rst_n = r; en = e; load = ld; value = v; dp_in = d; hex_mode = hx; lz_blank = lz;
        @(posedge clk);
        #1;
        if (!r) begin
            pos = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0;
            m_pend = 0; m_fs = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            m_fs = e && (pos == FR - 1);
            if (e) pos = (pos + 1) % FR;
            if (m_fs) begin
                if (ld) begin m_val = v; m_dp = d; end
                else if (m_pend) begin m_val = m_pval; m_dp = m_pdp; end
                m_pend = 0;
            end else if (ld) begin
                m_pval = v; m_pdp = d; m_pend = 1;
            end
        end
        dig  = pos / SD;
        slot = pos % SD;
        nib  = 4'((m_val >> (4 * dig)) & 16'hF);
        bad  = 0;
        for (int k = 0; k < D; k++) if (((m_val >> (4 * k)) & 16'hF) > 9) bad = 1;
        e_an = 4'hF;
        if (!m_rst && e && slot >= BC) e_an[dig] = 1'b0;
        if (m_rst || !e)                                        e_seg = 7'h7F;
        else if (lz && dig > 0 && (m_val >> (4 * dig)) == 16'd0) e_seg = 7'h7F;
        else if (!hx && nib > 9)                                e_seg = 7'h3F;
        else                                                    e_seg = tbl[nib];
        chk("an_n", 32'(an_n), 32'(e_an));
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n", 32'(dp_n), 32'((m_rst || !e) ? 1'b1 : !m_dp[dig]));
        chk("digit_idx", 32'(digit_idx), 32'(dig));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("bcd_err", 32'(bcd_err), 32'(!m_rst && !hx && bad));
    endtask

    task automatic run(input int n, input bit hx, input bit lz, input logic [3:0] d);
        for (int i = 0; i < n; i++) step(1, 1, 0, 16'h0, d, hx, lz);
    endtask

    initial begin
        pos = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_pend = 0; m_fs = 0; m_rst = 1;
        step(0, 0, 0, 16'h0, 4'h0, 1, 0);
        chk("rst_an_const", 32'(an_n), 32'hF);
        chk("rst_seg_const", 32'(seg_n), 32'h7F);

        // Plan 1: load 1234 then scan several frames.
        step(1, 1, 0, 16'h0, 4'h0, 1, 0);
        step(1, 1, 1, 16'h1234, 4'h0, 1, 0);
        run(40, 1, 0, 4'h0);
        // Plan 2: two mid-frame loads, last wins, with LZ blanking.
        step(1, 1, 1, 16'hABCD, 4'h0, 1, 1);
        step(1, 1, 1, 16'h00EF, 4'h0, 1, 1);
        run(36, 1, 1, 4'h0);
        // Plan 3: BCD dash / bcd_err, then back to hex.
        step(1, 1, 1, 16'h12A4, 4'h0, 0, 0);
        run(20, 0, 0, 4'h0);
        run(6, 1, 0, 4'h0);
        // Plan 4: zero value, LZ blank, dp on digit 2.
        step(1, 1, 1, 16'h0000, 4'b0100, 1, 1);
        run(36, 1, 1, 4'h0);
        // Plan 5: disable mid-slot in digit 2.
        while (pos != 2 * SD + 1) step(1, 1, 0, 16'h0, 4'h0, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0, 4'h0, 1, 1);
        run(8, 1, 1, 4'h0);
        // Plan 6: reset mid-frame with a pending load.
        step(1, 1, 1, 16'h5678, 4'hF, 1, 0);
        step(0, 1, 0, 16'h0, 4'h0, 1, 0);
        run(36, 1, 0, 4'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) != 0), ($urandom_range(9) != 0), ($urandom_range(9) == 0),
                 16'($urandom), 4'($urandom), ($urandom_range(3) != 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
